// File: rtl/ps2_rx_mmio.sv
// Memory-mapped PS/2 keyboard receiver: deserialises device-to-host frames into a
// byte FIFO that the core drains through DATA/STATUS loads in the MEM stage.
module ps2_rx_mmio #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_data,
  input  logic        i_en,
  input  logic        i_rdEn,
  input  logic [31:0] i_addr,
  output logic [31:0] o_rdData,
  output logic        o_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic          ps2_data_p0, ps2_data_p1;
  logic          fall;
  state_t        state;
  logic [2:0]    bitcnt;
  logic [TW-1:0] tcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          timeout, stop_edge, par_ok, push, perr_set, ferr_set;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [4:0]    count5;
  logic          ovf, perr, ferr;
  logic          rd_data, rd_stat, empty, full, pop, wr, ovf_set;
  logic          unused_addr;

  assign unused_addr = ^{i_addr[31:3], i_addr[1:0]};

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous synced clock level
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_clk_p2  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= i_ps2_clk;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= i_ps2_data;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  assign fall      = ps2_clk_p2 & ~ps2_clk_p1;
  assign timeout   = (state != IDLE) && !fall && (tcnt == TMAX);
  assign stop_edge = fall && (state == STOP);
  assign par_ok    = ^{shreg, par_bit};
  assign push      = stop_edge & ps2_data_p1 & par_ok;
  assign perr_set  = stop_edge & ps2_data_p1 & ~par_ok;
  assign ferr_set  = (stop_edge & ~ps2_data_p1) | timeout;

  // Frame FSM: advances on synced falling edges, aborts a stalled frame on timeout
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      bitcnt <= 3'd0;
      tcnt   <= '0;
    end else begin
      if (state == IDLE || fall || timeout) tcnt <= '0;
      else                                  tcnt <= tcnt + TW'(1);
      if (timeout) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: if (!ps2_data_p1) begin
            state  <= DATA;
            bitcnt <= 3'd0;
          end
          DATA: begin
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY:  state <= STOP;
          STOP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (fall && state == DATA)   shreg   <= {ps2_data_p1, shreg[7:1]};
    if (fall && state == PARITY) par_bit <= ps2_data_p1;
  end

  assign rd_data   = i_en & i_rdEn & ~i_addr[2];
  assign rd_stat   = i_en & i_rdEn & i_addr[2];
  assign empty     = (count == '0);
  assign full      = (count == FULL);
  assign pop       = rd_data & ~empty;
  assign wr        = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;
  assign count_nxt = count + CW'(wr) - CW'(pop);
  assign count5    = 5'(count);

  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, sticky flags and the registered read port; a set beats a status clear
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      o_rdData <= 32'd0;
      o_irq    <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      o_irq <= (count_nxt != '0);
      ovf   <= ovf_set  | (ovf  & ~rd_stat);
      perr  <= perr_set | (perr & ~rd_stat);
      ferr  <= ferr_set | (ferr & ~rd_stat);
      if (rd_data)
        o_rdData <= empty ? 32'd0 : {23'd0, 1'b1, mem[rd_ptr]};
      else if (rd_stat)
        o_rdData <= {11'd0, count5, 12'd0, ferr, perr, ovf, ~empty};
    end
  end

endmodule

// File: tb/tb_ps2_rx_mmio.sv
// Bench for ps2_rx_mmio: bit-banged PS/2 frames, MMIO reads scored against a queue
// of expected words, plus sequences for overflow, timeout and mid-frame reset.
module tb_ps2_rx_mmio;
  localparam int DEPTH = 8;
  localparam int TO    = 200;
  localparam int HALF  = 10;

  logic        clk = 1'b0;
  logic        rst, ps2_clk, ps2_data, en, rd_en;
  logic [31:0] addr, rd_data;
  logic        irq;
  logic        rd_seen = 1'b0;
  int          total = 0;
  int          bad = 0;

  typedef struct { logic [31:0] exp; string name; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0]  d;
    logic        par_flip;
    logic        stop;
    logic [31:0] st;
    logic        irq;
    logic [31:0] dat;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  ps2_rx_mmio #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .i_en      (en),
    .i_rdEn    (rd_en),
    .i_addr    (addr),
    .o_rdData  (rd_data),
    .o_irq     (irq)
  );

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  always @(posedge clk) rd_seen <= en & rd_en;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read got=%h want=none", rd_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, rd_data, e.exp);
      end
    end
  end

  task automatic rd(input logic a2, input logic [31:0] exp, input string name);
    @(negedge clk);
    addr  = a2 ? 32'h8000_0004 : 32'h8000_0008;
    en    = 1'b1;
    rd_en = 1'b1;
    sb.push_back('{exp, name});
    @(negedge clk);
    en    = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic ps2_bit(input logic b, input logic co, input logic [31:0] co_exp);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF - 1) @(negedge clk);
    ps2_clk = 1'b0;
    if (co) begin
      repeat (2) @(negedge clk);
      addr  = 32'h0;
      en    = 1'b1;
      rd_en = 1'b1;
      sb.push_back('{co_exp, "rd_at_push"});
      @(negedge clk);
      en    = 1'b0;
      rd_en = 1'b0;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input logic par_flip, input logic stop,
                       input logic co, input logic [31:0] co_exp);
    ps2_bit(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0, 32'd0);
    ps2_bit((~^d) ^ par_flip, 1'b0, 32'd0);
    ps2_bit(stop, co, co_exp);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{8'h1C, 1'b0, 1'b1, 32'h0001_0001, 1'b1, 32'h0000_011C};
    tbl[1] = '{8'h1C, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000};
    tbl[2] = '{8'hA5, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 32'h0000_0000};
    tbl[3] = '{8'hFF, 1'b0, 1'b1, 32'h0001_0001, 1'b1, 32'h0000_01FF};
    tbl[4] = '{8'h00, 1'b0, 1'b1, 32'h0001_0001, 1'b1, 32'h0000_0100};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; en = 1'b0; rd_en = 1'b0; addr = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_rddata", rd_data, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    rd(1'b1, 32'd0, "status_after_reset");

    for (int i = 0; i < 5; i++) begin
      frame(tbl[i].d, tbl[i].par_flip, tbl[i].stop, 1'b0, 32'd0);
      check("vec_irq", 32'(irq), 32'(tbl[i].irq));
      rd(1'b1, tbl[i].st, "vec_status");
      rd(1'b0, tbl[i].dat, "vec_data");
      rd(1'b1, 32'd0, "vec_status_clr");
      @(negedge clk);
      check("vec_irq_drained", 32'(irq), 32'd0);
    end

    for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b1, 1'b0, 32'd0);
    check("nine_irq", 32'(irq), 32'd1);
    @(negedge clk);
    addr = 32'h4; rd_en = 1'b1; en = 1'b0;
    repeat (3) @(negedge clk);
    rd_en = 1'b0;
    rd(1'b1, 32'h0008_0003, "nine_status");
    @(negedge clk);
    addr = 32'h0; rd_en = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      en = 1'b1;
      sb.push_back('{32'(32'h100 + i), "held_rden_data"});
      @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);
    end
    rd_en = 1'b0;
    for (int i = 3; i <= 8; i++) rd(1'b0, 32'(32'h100 + i), "nine_data");
    rd(1'b0, 32'd0, "nine_empty");

    ps2_bit(1'b0, 1'b0, 32'd0);
    ps2_bit(1'b1, 1'b0, 32'd0);
    ps2_bit(1'b0, 1'b0, 32'd0);
    ps2_bit(1'b1, 1'b0, 32'd0);
    ps2_bit(1'b0, 1'b0, 32'd0);
    repeat (TO - 40) @(negedge clk);
    rd(1'b1, 32'd0, "status_before_timeout");
    repeat (40) @(negedge clk);
    rd(1'b1, 32'h0000_0008, "status_timeout");
    frame(8'hAA, 1'b0, 1'b1, 1'b0, 32'd0);
    rd(1'b0, 32'h0000_01AA, "data_after_timeout");
    rd(1'b1, 32'd0, "status_after_timeout_frame");

    for (int i = 0; i < DEPTH; i++) frame(8'(8'h11 + i), 1'b0, 1'b1, 1'b0, 32'd0);
    rd(1'b1, 32'h0008_0001, "full_status");
    frame(8'h55, 1'b0, 1'b1, 1'b1, 32'h0000_0111);
    rd(1'b1, 32'h0008_0001, "status_push_pop_full");
    for (int i = 0; i < DEPTH - 1; i++) rd(1'b0, 32'(32'h112 + i), "full_drain");
    rd(1'b0, 32'h0000_0155, "full_last_entry");
    rd(1'b0, 32'd0, "full_empty");

    frame(8'h77, 1'b0, 1'b1, 1'b0, 32'd0);
    rd(1'b1, 32'h0001_0001, "pre_reset_status");
    ps2_bit(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) ps2_bit(((8'h3C >> i) & 8'h01) != 0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midframe_reset_rddata", rd_data, 32'd0);
    check("midframe_reset_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    ps2_bit(1'b1, 1'b0, 32'd0);
    ps2_bit(1'b0, 1'b0, 32'd0);
    ps2_bit(1'b0, 1'b0, 32'd0);
    ps2_bit(1'b1, 1'b0, 32'd0);
    ps2_bit(1'b1, 1'b0, 32'd0);
    repeat (TO + 20) @(negedge clk);
    frame(8'h3C, 1'b0, 1'b1, 1'b0, 32'd0);
    rd(1'b1, 32'h0001_0009, "post_reset_status");
    rd(1'b0, 32'h0000_013C, "post_reset_data");
    rd(1'b0, 32'd0, "post_reset_empty");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_rx_mmio.md
Name: ps2_rx_mmio

Overview:
- Memory-mapped PS/2 keyboard receiver: the input direction of the core's peripheral bus, complementing the store-only VGA pixel path.
- Deserialises PS/2 device-to-host frames, buffers bytes in a FIFO, and returns them to the core on loads issued in the MEM stage.
- Sits beside the VGA block, driven by the ALU result address, the MEM-stage read control and the en_MEM enable.

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries; power of 2, range 2..16.
- TIMEOUT_CYC, 5000, i_clk cycles without a PS/2 falling edge before a partial frame is aborted.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous reset, active-high
- i_ps2_clk  in  1  PS/2 clock pin, asynchronous
- i_ps2_data  in  1  PS/2 data pin, asynchronous
- i_en  in  1  stage qualifier (en_MEM); reads act only when high
- i_rdEn  in  1  load targets this peripheral
- i_addr  in  32  byte address; only bit 2 decoded (0 = DATA, 1 = STATUS)
- o_rdData  out  32  registered read data
- o_irq  out  1  FIFO non-empty

Behaviour:
- Reset (async, i_reset=1): FSM=IDLE, FIFO empty, all sticky flags 0, o_rdData=0, o_irq=0, synchronisers load 1, timeout counter 0.
- Sync: 2-FF synchroniser on each pin. Falling edge = previous synced clk 1 and current 0. Synced data is sampled on that same cycle.
- FSM (advances only on a falling edge, except timeout):
  - IDLE: data 0 -> DATA with bitcnt=0; data 1 -> stay.
  - DATA: shift data in LSB-first; after the 8th bit -> PARITY.
  - PARITY: store parity bit -> STOP.
  - STOP: result depends on the stop bit and parity, then -> IDLE.
    - stop=1 and odd parity OK (XOR of 8 data bits and parity = 1): push byte.
    - stop=1, parity bad: set PERR, discard byte.
    - stop=0: set FERR, discard byte.
- Timeout:
  - Counter clears on every falling edge and in IDLE; it increments each cycle otherwise.
  - On reaching TIMEOUT_CYC-1: FSM -> IDLE, set FERR, discard partial byte.
- FIFO push:
  - When full, push is dropped and OVF is set.
  - Push and pop in the same cycle both succeed, including when full; count is unchanged and OVF is not set.
- Read (i_en & i_rdEn), o_rdData valid on the next cycle and held until the next read:
  - DATA: {23'b0, valid, byte}, then pop. On empty returns 0 and does not pop.
  - STATUS: returns the word below. It clears OVF/PERR/FERR; a flag set on the same cycle wins over the clear.
    - bit0 non-empty
    - bit1 OVF
    - bit2 PERR
    - bit3 FERR
    - bits[20:16] count
    - all other bits 0
- Reads without i_en have no effect. Multi-cycle i_rdEn with i_en pulsing pops once per i_en pulse.
- o_irq = count != 0, registered with the FIFO.
- Reset mid-frame aborts the frame immediately; no byte is pushed.
- PS/2 clock edges closer than 3 i_clk cycles are not required to be captured (the PS/2 clock is ≤16.7 kHz).

Test Plan:
- Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) then read DATA -> o_rdData=0x0000011C; following STATUS read -> 0x00000000, o_irq=0.
- Frame 0x1C with parity 1 -> FIFO stays empty, STATUS=0x00000004; second STATUS read -> 0x00000000.
- Nine good frames 0x01..0x09, no reads:
  - STATUS -> 0x00080003.
  - Eight DATA reads -> 0x101..0x108.
  - A ninth DATA read -> 0x00000000.
- Start bit plus 4 data bits, then clock idle:
  - Exactly TIMEOUT_CYC cycles after the last edge, FSM is IDLE and STATUS=0x00000008.
  - A following good frame 0xAA is received as 0x1AA.
- FIFO full:
  - A DATA read whose pop coincides with the STOP-edge push of 0x55 -> count stays 8, OVF=0.
  - The last entry is 0x155.
- Assert i_reset after 6 bits of a frame -> outputs return to reset values. The remaining bits plus a fresh full frame 0x3C yield a FIFO holding only 0x13C; the stray bits must not push a byte.
